// File: rtl/tl_byte_master.sv
// Byte-stream to TileLink-UL initiator: decodes framed read/write commands from a
// byte FIFO, issues one A request, and returns status/read data as framed bytes.
module tl_byte_master #(
    parameter int DATA_W    = 64,
    parameter int ADDR_W    = 64,
    parameter int SOURCE_ID = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_empty,
    input  logic [7:0]        cmd_dout,
    output logic              cmd_rd_en,
    input  logic              res_full,
    output logic              res_wr_en,
    output logic [7:0]        res_din,
    output logic              a_valid,
    input  logic              a_ready,
    output logic [2:0]        a_opcode,
    output logic [2:0]        a_param,
    output logic [2:0]        a_size,
    output logic [3:0]        a_source,
    output logic [ADDR_W-1:0] a_address,
    output logic [7:0]        a_mask,
    output logic [DATA_W-1:0] a_data,
    input  logic              d_valid,
    output logic              d_ready,
    input  logic [2:0]        d_opcode,
    input  logic              d_denied,
    input  logic [DATA_W-1:0] d_data,
    output logic              busy
);
    typedef enum logic [2:0] {IDLE, ADDR, WDATA, REQ, RESP, STATUS, RDATA} state_t;

    localparam logic [7:0] OP_READ  = 8'h01;
    localparam logic [7:0] OP_WRITE = 8'h02;

    state_t            state;
    logic [3:0]        cnt;
    logic [7:0]        op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic [2:0]        rsp_opcode;
    logic              rsp_denied;
    logic [7:0]        status;

    // Handshakes are gated by rst so no byte moves while reset is asserted.
    assign cmd_rd_en = !rst && !cmd_empty && (state inside {IDLE, ADDR, WDATA});
    assign res_wr_en = !rst && !res_full && (state inside {STATUS, RDATA});
    assign a_valid   = (state == REQ);
    assign d_ready   = (state == RESP);
    assign busy      = (state != IDLE);

    assign a_opcode  = (op == OP_WRITE) ? 3'd0 : 3'd4;
    assign a_param   = 3'd0;
    assign a_size    = 3'd3;
    assign a_source  = 4'(SOURCE_ID);
    assign a_address = addr;
    assign a_mask    = 8'hFF;
    assign a_data    = (op == OP_WRITE) ? wdata : '0;

    always_comb begin
        status = 8'h00;
        if (op != OP_READ && op != OP_WRITE)
            status = 8'hFF;
        else if (rsp_denied)
            status = 8'h01;
        else if (rsp_opcode != ((op == OP_READ) ? 3'd1 : 3'd0))
            status = 8'h02;
    end

    always_comb begin
        res_din = 8'h00;
        case (state)
            STATUS:  res_din = status;
            RDATA:   res_din = rdata[{cnt[2:0], 3'b000} +: 8];
            default: res_din = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            op         <= 8'h00;
            addr       <= '0;
            wdata      <= '0;
            rdata      <= '0;
            rsp_opcode <= 3'd0;
            rsp_denied <= 1'b0;
        end else begin
            case (state)
                IDLE: if (cmd_rd_en) begin
                    op    <= cmd_dout;
                    cnt   <= 4'd0;
                    state <= (cmd_dout == OP_READ || cmd_dout == OP_WRITE) ? ADDR : STATUS;
                end
                ADDR: if (cmd_rd_en) begin
                    // Bytes arrive LSB first, so shift in from the top.
                    addr <= {cmd_dout, addr[ADDR_W-1:8]};
                    cnt  <= cnt + 4'd1;
                    if (cnt == 4'd7) begin
                        cnt   <= 4'd0;
                        state <= (op == OP_WRITE) ? WDATA : REQ;
                    end
                end
                WDATA: if (cmd_rd_en) begin
                    wdata <= {cmd_dout, wdata[DATA_W-1:8]};
                    cnt   <= cnt + 4'd1;
                    if (cnt == 4'd7) begin
                        cnt   <= 4'd0;
                        state <= REQ;
                    end
                end
                REQ: if (a_ready) begin
                    cnt   <= 4'd0;
                    state <= RESP;
                end
                RESP: if (d_valid) begin
                    rsp_opcode <= d_opcode;
                    rsp_denied <= d_denied;
                    rdata      <= d_data;
                    cnt        <= 4'd0;
                    state      <= STATUS;
                end
                STATUS: if (res_wr_en) begin
                    cnt   <= 4'd0;
                    state <= (op == OP_READ) ? RDATA : IDLE;
                end
                RDATA: if (res_wr_en) begin
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd7) begin
                        cnt   <= 4'd0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tl_byte_master.sv
// Bench for tl_byte_master: FIFO and TileLink slave models driven cycle by cycle,
// with a frame-level reference model predicting requests and response bytes.
module tb_tl_byte_master;
    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_empty;
    logic [7:0]  cmd_dout;
    logic        cmd_rd_en;
    logic        res_full;
    logic        res_wr_en;
    logic [7:0]  res_din;
    logic        a_valid;
    logic        a_ready;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [2:0]  a_size;
    logic [3:0]  a_source;
    logic [63:0] a_address;
    logic [7:0]  a_mask;
    logic [63:0] a_data;
    logic        d_valid;
    logic        d_ready;
    logic [2:0]  d_opcode;
    logic        d_denied;
    logic [63:0] d_data;
    logic        busy;

    tl_byte_master #(.DATA_W(64), .ADDR_W(64), .SOURCE_ID(5)) dut (
        .clk(clk), .rst(rst),
        .cmd_empty(cmd_empty), .cmd_dout(cmd_dout), .cmd_rd_en(cmd_rd_en),
        .res_full(res_full), .res_wr_en(res_wr_en), .res_din(res_din),
        .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
        .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
        .a_data(a_data), .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode),
        .d_denied(d_denied), .d_data(d_data), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0]  cmd_q[$];
    logic [7:0]  res_q[$];
    logic [7:0]  exp_res[$];
    logic [7:0]  ref_bytes[$];
    logic [2:0]  exp_aop[$];
    logic [63:0] exp_addr[$];
    logic [63:0] exp_wdata[$];
    logic [2:0]  sr_op[$];
    logic        sr_den[$];
    logic [63:0] sr_data[$];
    int          sr_dly[$];

    bit          d_pend = 0;
    int          d_dly = 0;
    bit          toggle_en = 0;
    int          aready_hold = 0;
    int          full_at = 0;
    int          full_left = 0;
    int          cyc = 0;
    int          n_areq = 0;
    int          n_wait = 0;
    int          t_pop0 = -1;
    int          t_stat = -1;
    bit          a_wait = 0;
    logic [2:0]  hold_op;
    logic [63:0] hold_addr;
    logic [63:0] hold_data;

    // Reference model: one frame in terms of bytes in, request out, bytes back.
    task automatic add_frame(input logic [7:0] op, input logic [63:0] addr, input logic [63:0] wd,
                             input logic [2:0] dop, input logic den, input logic [63:0] dd,
                             input int dly);
        logic [7:0] st;
        cmd_q.push_back(op);
        if (op == 8'h01 || op == 8'h02) begin
            for (int i = 0; i < 8; i++) cmd_q.push_back(addr[8*i +: 8]);
            if (op == 8'h02)
                for (int i = 0; i < 8; i++) cmd_q.push_back(wd[8*i +: 8]);
            exp_aop.push_back(op == 8'h01 ? 3'd4 : 3'd0);
            exp_addr.push_back(addr);
            exp_wdata.push_back(op == 8'h02 ? wd : 64'h0);
            sr_op.push_back(dop);
            sr_den.push_back(den);
            sr_data.push_back(dd);
            sr_dly.push_back(dly);
            if (den) st = 8'h01;
            else if (dop != (op == 8'h01 ? 3'd1 : 3'd0)) st = 8'h02;
            else st = 8'h00;
            exp_res.push_back(st);
            if (op == 8'h01)
                for (int i = 0; i < 8; i++) exp_res.push_back(dd[8*i +: 8]);
        end else begin
            exp_res.push_back(8'hFF);
        end
    endtask

    task automatic clear_env();
        res_q.delete();
        exp_res.delete();
        toggle_en = 0;
        aready_hold = 0;
        full_at = 0;
        full_left = 0;
        n_wait = 0;
        t_pop0 = -1;
        t_stat = -1;
    endtask

    // One clock: drive inputs after the falling edge, observe what the next rising edge does.
    task automatic step();
        bit just_req;
        just_req  = 0;
        cmd_empty = (cmd_q.size() == 0) || (toggle_en && cyc[0]);
        cmd_dout  = (cmd_q.size() != 0) ? cmd_q[0] : 8'h00;
        res_full  = (full_left > 0);
        a_ready   = (aready_hold == 0);
        if (d_pend && d_dly == 0 && sr_op.size() != 0) begin
            d_valid = 1'b1; d_opcode = sr_op[0]; d_denied = sr_den[0]; d_data = sr_data[0];
        end else if (!d_pend) begin
            d_valid = 1'($urandom); d_opcode = 3'($urandom); d_denied = 1'($urandom);
            d_data = {$urandom, $urandom};
        end else begin
            d_valid = 1'b0;
        end
        #1;
        checks++;
        if (d_ready !== d_pend) begin
            errors++; $display("FAIL d_ready: got %b expected %b at cycle %0d", d_ready, d_pend, cyc);
        end
        if (cmd_rd_en) begin
            checks++;
            if (cmd_empty || cmd_q.size() == 0) begin
                errors++; $display("FAIL pop_while_empty at cycle %0d", cyc);
            end else begin
                void'(cmd_q.pop_front());
                if (t_pop0 < 0) t_pop0 = cyc;
            end
        end
        if (res_wr_en) begin
            checks++;
            if (res_full) begin
                errors++; $display("FAIL push_while_full at cycle %0d", cyc);
            end
            res_q.push_back(res_din);
            if (t_stat < 0) t_stat = cyc;
        end
        if (d_valid && d_ready && d_pend && d_dly == 0) begin
            void'(sr_op.pop_front()); void'(sr_den.pop_front());
            void'(sr_data.pop_front()); void'(sr_dly.pop_front());
            d_pend = 0;
        end
        if (a_valid) begin
            if (!a_wait) begin
                hold_op = a_opcode; hold_addr = a_address; hold_data = a_data; a_wait = 1;
            end else begin
                checks++;
                if ({a_opcode, a_address, a_data} !== {hold_op, hold_addr, hold_data}) begin
                    errors++;
                    $display("FAIL a_stable: got op=%0d addr=%h data=%h expected op=%0d addr=%h data=%h",
                             a_opcode, a_address, a_data, hold_op, hold_addr, hold_data);
                end
            end
            if (a_ready) begin
                a_wait = 0; n_areq++; checks++;
                if (exp_aop.size() == 0) begin
                    errors++; $display("FAIL a_request: got unexpected request addr=%h expected none", a_address);
                end else begin
                    if (a_opcode !== exp_aop[0] || a_address !== exp_addr[0] || a_data !== exp_wdata[0] ||
                        a_mask !== 8'hFF || a_size !== 3'd3 || a_param !== 3'd0 || a_source !== 4'd5) begin
                        errors++;
                        $display("FAIL a_fields: got op=%0d addr=%h data=%h mask=%h size=%0d param=%0d src=%0d expected op=%0d addr=%h data=%h mask=ff size=3 param=0 src=5",
                                 a_opcode, a_address, a_data, a_mask, a_size, a_param, a_source,
                                 exp_aop[0], exp_addr[0], exp_wdata[0]);
                    end
                    void'(exp_aop.pop_front()); void'(exp_addr.pop_front()); void'(exp_wdata.pop_front());
                end
                d_pend = 1; just_req = 1;
                d_dly = (sr_dly.size() != 0) ? sr_dly[0] : 0;
            end else begin
                n_wait++;
                if (aready_hold > 0) aready_hold--;
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (d_pend && d_dly > 0 && !just_req) d_dly--;
        if (full_left > 0) full_left--;
        if (full_at > 0 && res_q.size() == full_at) begin
            full_left = 4; full_at = 0;
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((cmd_q.size() != 0 || res_q.size() < exp_res.size() || busy) && n < 3000) begin
            step(); n++;
        end
        step(); step();
        checks++;
        if (n >= 3000) begin
            errors++; $display("FAIL %s_timeout: got %0d bytes expected %0d", name, res_q.size(), exp_res.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_empty = 1'b0; cmd_dout = 8'h01; res_full = 1'b0;
        a_ready = 1'b1; d_valid = 1'b0; d_opcode = 3'd0; d_denied = 1'b0; d_data = 64'h0;
        @(negedge clk); @(negedge clk); #1;
        checks += 8;
        if (cmd_rd_en !== 1'b0) begin errors++; $display("FAIL rst_cmd_rd_en: got %b expected 0", cmd_rd_en); end
        if (res_wr_en !== 1'b0) begin errors++; $display("FAIL rst_res_wr_en: got %b expected 0", res_wr_en); end
        if (a_valid !== 1'b0) begin errors++; $display("FAIL rst_a_valid: got %b expected 0", a_valid); end
        if (d_ready !== 1'b0) begin errors++; $display("FAIL rst_d_ready: got %b expected 0", d_ready); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        if (res_din !== 8'h00) begin errors++; $display("FAIL rst_res_din: got %h expected 00", res_din); end
        if (a_address !== 64'h0) begin errors++; $display("FAIL rst_a_address: got %h expected 0", a_address); end
        if (a_data !== 64'h0) begin errors++; $display("FAIL rst_a_data: got %h expected 0", a_data); end
        cmd_empty = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_read();
        logic [7:0] lit [9];
        lit = '{8'h00, 8'h88, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
        clear_env();
        add_frame(8'h01, 64'h1000, 64'h0, 3'd1, 1'b0, 64'h1122334455667788, 3);
        drain("read");
        checks++;
        if (res_q.size() != 9) begin errors++; $display("FAIL read_len: got %0d expected 9", res_q.size()); end
        for (int i = 0; i < 9 && i < res_q.size(); i++) begin
            checks++;
            if (res_q[i] !== lit[i]) begin errors++; $display("FAIL read_byte%0d: got %h expected %h", i, res_q[i], lit[i]); end
        end
        checks++;
        if (t_stat - t_pop0 != 14) begin errors++; $display("FAIL read_latency: got %0d expected 14", t_stat - t_pop0); end
        ref_bytes = res_q;
    endtask

    task automatic test_write();
        clear_env();
        add_frame(8'h02, 64'h2000, 64'hDEADBEEFCAFEF00D, 3'd0, 1'b0, 64'h0, 3);
        drain("write");
        checks++;
        if (res_q.size() != 1 || res_q[0] !== 8'h00) begin
            errors++; $display("FAIL write_resp: got %0d bytes first=%h expected 1 byte 00", res_q.size(),
                               (res_q.size() != 0) ? res_q[0] : 8'hxx);
        end
        checks++;
        if (t_stat - t_pop0 != 22) begin errors++; $display("FAIL write_latency: got %0d expected 22", t_stat - t_pop0); end
    endtask

    task automatic test_unknown();
        int n0;
        clear_env();
        n0 = n_areq;
        add_frame(8'h7E, 64'h0, 64'h0, 3'd0, 1'b0, 64'h0, 0);
        add_frame(8'h01, 64'h3008, 64'h0, 3'd1, 1'b0, 64'hA5A5_0102_0304_5A5A, 1);
        drain("unknown");
        checks++;
        if (n_areq - n0 != 1) begin errors++; $display("FAIL unknown_nreq: got %0d expected 1", n_areq - n0); end
        checks++;
        if (res_q.size() != exp_res.size()) begin errors++; $display("FAIL unknown_len: got %0d expected %0d", res_q.size(), exp_res.size()); end
        for (int i = 0; i < exp_res.size() && i < res_q.size(); i++) begin
            checks++;
            if (res_q[i] !== exp_res[i]) begin errors++; $display("FAIL unknown_byte%0d: got %h expected %h", i, res_q[i], exp_res[i]); end
        end
    endtask

    task automatic test_backpressure();
        clear_env();
        add_frame(8'h01, 64'h1000, 64'h0, 3'd1, 1'b0, 64'h1122334455667788, 3);
        toggle_en = 1; aready_hold = 5; full_at = 3;
        drain("backpressure");
        checks++;
        if (n_wait != 5) begin errors++; $display("FAIL bp_a_wait: got %0d expected 5", n_wait); end
        checks++;
        if (res_q.size() != ref_bytes.size()) begin errors++; $display("FAIL bp_len: got %0d expected %0d", res_q.size(), ref_bytes.size()); end
        for (int i = 0; i < ref_bytes.size() && i < res_q.size(); i++) begin
            checks++;
            if (res_q[i] !== ref_bytes[i]) begin errors++; $display("FAIL bp_byte%0d: got %h expected %h", i, res_q[i], ref_bytes[i]); end
        end
    endtask

    task automatic test_errors();
        clear_env();
        add_frame(8'h01, 64'h4000, 64'h0, 3'd1, 1'b1, 64'hCAFE_0000_BEEF_0001, 2);
        add_frame(8'h01, 64'h4008, 64'h0, 3'd0, 1'b0, 64'h0123_4567_89AB_CDEF, 0);
        add_frame(8'h02, 64'h4010, 64'h55AA, 3'd1, 1'b0, 64'h0, 1);
        drain("errors");
        checks += 3;
        if (res_q.size() > 0 && res_q[0] !== 8'h01) begin errors++; $display("FAIL err_denied: got %h expected 01", res_q[0]); end
        if (res_q.size() > 9 && res_q[9] !== 8'h02) begin errors++; $display("FAIL err_rd_opcode: got %h expected 02", res_q[9]); end
        if (res_q.size() != 19) begin errors++; $display("FAIL err_len: got %0d expected 19", res_q.size()); end
        for (int i = 0; i < exp_res.size() && i < res_q.size(); i++) begin
            checks++;
            if (res_q[i] !== exp_res[i]) begin errors++; $display("FAIL err_byte%0d: got %h expected %h", i, res_q[i], exp_res[i]); end
        end
    endtask

    task automatic test_random();
        logic [7:0] op;
        logic [2:0] good;
        logic [2:0] dop;
        logic       den;
        int         r;
        int         k;
        clear_env();
        for (int f = 0; f < 25; f++) begin
            r = $urandom_range(0, 9);
            if (r <= 3) op = 8'h01;
            else if (r <= 7) op = 8'h02;
            else if (r == 8) op = 8'h00;
            else op = 8'($urandom_range(3, 255));
            good = (op == 8'h01) ? 3'd1 : 3'd0;
            k = $urandom_range(0, 3);
            den = (k == 2);
            dop = (k == 3) ? (good ^ 3'($urandom_range(1, 7))) : good;
            add_frame(op, {$urandom, $urandom}, {$urandom, $urandom}, dop, den,
                      {$urandom, $urandom}, $urandom_range(0, 4));
        end
        toggle_en = 1; aready_hold = 3; full_at = 6;
        drain("random");
        checks++;
        if (res_q.size() != exp_res.size()) begin errors++; $display("FAIL rand_len: got %0d expected %0d", res_q.size(), exp_res.size()); end
        for (int i = 0; i < exp_res.size() && i < res_q.size(); i++) begin
            checks++;
            if (res_q[i] !== exp_res[i]) begin errors++; $display("FAIL rand_byte%0d: got %h expected %h", i, res_q[i], exp_res[i]); end
        end
        checks++;
        if (exp_aop.size() != 0) begin errors++; $display("FAIL rand_reqs: got %0d requests missing expected 0", exp_aop.size()); end
    endtask

    task automatic test_mid_reset();
        int n;
        clear_env();
        cmd_q.push_back(8'h01);
        for (int i = 0; i < 4; i++) cmd_q.push_back(8'($urandom));
        n = 0;
        while (cmd_q.size() != 0 && n < 50) begin step(); n++; end
        step();
        checks++;
        if (n >= 50) begin errors++; $display("FAIL mid_pop_timeout: got %0d bytes left expected 0", cmd_q.size()); end
        rst = 1'b1; cmd_empty = 1'b0; cmd_dout = 8'h02; d_valid = 1'b0; a_ready = 1'b1; res_full = 1'b0;
        #1;
        checks += 6;
        if (cmd_rd_en !== 1'b0) begin errors++; $display("FAIL mid_cmd_rd_en: got %b expected 0", cmd_rd_en); end
        if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", busy); end
        if (a_valid !== 1'b0 || d_ready !== 1'b0) begin errors++; $display("FAIL mid_handshake: got a_valid=%b d_ready=%b expected 0 0", a_valid, d_ready); end
        if (res_wr_en !== 1'b0) begin errors++; $display("FAIL mid_res_wr_en: got %b expected 0", res_wr_en); end
        if (a_address !== 64'h0) begin errors++; $display("FAIL mid_a_address: got %h expected 0", a_address); end
        if (res_din !== 8'h00) begin errors++; $display("FAIL mid_res_din: got %h expected 00", res_din); end
        @(negedge clk); @(negedge clk);
        cmd_empty = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        add_frame(8'h01, 64'h0000_0000_8000_0040, 64'h0, 3'd1, 1'b0, 64'hFEDC_BA98_7654_3210, 1);
        drain("mid_reset");
        checks++;
        if (res_q.size() != exp_res.size()) begin errors++; $display("FAIL mid_len: got %0d expected %0d", res_q.size(), exp_res.size()); end
        for (int i = 0; i < exp_res.size() && i < res_q.size(); i++) begin
            checks++;
            if (res_q[i] !== exp_res[i]) begin errors++; $display("FAIL mid_byte%0d: got %h expected %h", i, res_q[i], exp_res[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_unknown();
        test_backpressure();
        test_errors();
        test_random();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/tl_byte_master.md
# tl_byte_master

Byte-stream-to-TileLink-UL initiator: pops framed command bytes from a command FIFO, issues one TileLink Get or PutFullData on channel A, waits for the channel D response, and pushes framed status/data bytes into a response FIFO. It is the initiator end of the bus that the ROM and other slaves respond on. It lets a host link (UART/JTAG byte pipe) drive memory-mapped reads and writes. One transaction is outstanding at a time.

## Interface
- `DATA_W`, default 64: TileLink data width; fixed at 64 (8 data bytes per frame).
- `ADDR_W`, default 64: address width; fixed at 64 (8 address bytes per frame).
- `SOURCE_ID`, default 0: constant driven on `a_source`.
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: reset, asynchronous, active-high.
- `cmd_empty` in 1: command FIFO empty; `cmd_dout` is valid when low (first-word fall-through).
- `cmd_dout` in 8: command byte at the FIFO head.
- `cmd_rd_en` out 1: pops one command byte this cycle.
- `res_full` in 1: response FIFO full.
- `res_wr_en` out 1: pushes `res_din` this cycle.
- `res_din` out 8: response byte.
- `a_valid` out 1, `a_ready` in 1: channel A handshake.
- `a_opcode` out 3: 4 = Get, 0 = PutFullData.
- `a_param` out 3: always 0.
- `a_size` out 3: always 3 (8 bytes).
- `a_source` out 4: `SOURCE_ID`.
- `a_address` out 64: request address.
- `a_mask` out 8: always 0xFF.
- `a_data` out 64: write data; 0 for Get.
- `d_valid` in 1, `d_ready` out 1: channel D handshake.
- `d_opcode` in 3: 1 = AccessAckData, 0 = AccessAck.
- `d_denied` in 1: the slave rejected the access.
- `d_data` in 64: read data.
- `busy` out 1: high in every state except IDLE.

## Operation
- Frame in: opcode byte, then 8 address bytes, least significant first. Opcode 0x01 = read. Opcode 0x02 = write, followed by 8 data bytes, least significant first.
- Frame out: one status byte. For a read, the status byte is followed by 8 bytes of `d_data`, least significant first.
- Status codes: 0x00 OK; 0x01 `d_denied`; 0x02 unexpected `d_opcode` (read expects 1, write expects 0); 0xFF unknown opcode.
- Unknown opcode: the opcode byte is consumed, 0xFF is emitted, and the FSM returns to IDLE without consuming further bytes.
- On a read with status 0x01 or 0x02, the captured `d_data` is still emitted as 8 bytes, so the frame length is fixed per opcode.
- FSM states and transitions:
  - IDLE → ADDR (opcode 0x01/0x02) or → STATUS (unknown opcode).
  - ADDR → WDATA (write) or → REQ (read) after 8 bytes.
  - WDATA → REQ after 8 bytes.
  - REQ → RESP on `a_valid & a_ready`.
  - RESP → STATUS on `d_valid & d_ready`.
  - STATUS → RDATA (read) or → IDLE after the status byte is pushed.
  - RDATA → IDLE after 8 bytes are pushed.
- A 4-bit byte counter indexes address and data bytes. It wraps to 0 on each state change.
- Address and write data are assembled in shift registers. The opcode, address, data and captured D fields are held until the frame completes.

## Timing
- Reset values: `cmd_rd_en`, `res_wr_en`, `a_valid`, `d_ready` and `busy` are 0. `res_din`, `a_address`, `a_data` and the byte counter are 0. State is IDLE.
- `cmd_rd_en = !cmd_empty` in IDLE, ADDR and WDATA; 0 otherwise. At most one byte is consumed per cycle. Stalls are unbounded while the FIFO is empty.
- `res_wr_en = !res_full` in STATUS and RDATA. `res_din` is combinational from state and counter. No byte is written while `res_full` is high.
- `a_valid` is high for the whole REQ state. All `a_*` fields are stable from REQ entry until the handshake, and `a_valid` does not drop before `a_ready`.
- `d_ready` is 1 only in RESP. `d_opcode`, `d_denied` and `d_data` are registered on the D handshake.
- Minimum read latency, with no stalls and D arriving k cycles after the A handshake:
  - Opcode popped at cycle 0; address popped at cycles 1–8.
  - `a_valid` at cycle 9 (handshake at 9 if `a_ready`).
  - D handshake at cycle 10+k.
  - Status byte at cycle 11+k; data bytes at cycles 12+k to 19+k.
- Minimum write: data popped at cycles 9–16, `a_valid` at cycle 17, status at cycle 19+k.
- `d_valid` while not in RESP is ignored; `d_ready` is 0 there.
- Reset mid-frame discards the partial frame: no A request and no response byte for it. The byte stream resynchronises on the next byte popped, which is treated as an opcode.

## Test plan
- Read: push 01 00 10 00 00 00 00 00 00; slave returns AccessAckData with `d_data` 0x1122334455667788 after 3 cycles → `a_address` = 0x1000, `a_opcode` = 4, `a_mask` = 0xFF; response bytes 00 88 77 66 55 44 33 22 11.
- Write: push 02, address 0x2000 (8 bytes), data 0xDEADBEEFCAFEF00D (8 bytes); slave returns AccessAck → `a_opcode` = 0, `a_data` = 0xDEADBEEFCAFEF00D; response byte 00.
- Unknown opcode 0x7E followed by a valid read frame → response 0xFF, then a normal 9-byte read response; exactly one A request.
- Backpressure: `a_ready` held low for 5 cycles, `cmd_empty` toggled every other cycle, `res_full` held high for 4 cycles during RDATA → A fields stable while `a_valid` waits, no bytes lost or duplicated, final byte sequence identical to the no-stall case.
- Error responses: `d_denied` = 1 on a read → status 01 followed by 8 bytes; AccessAck returned for a read → status 02.
- Reset asserted after 4 address bytes → all outputs 0 within the reset; a fresh read frame afterwards completes correctly.
